// File: rtl/fpu_sequencer_if.sv
// ============================================================================
// fpu_sequencer_if : issue, decode-hazard, FPU launch and writeback bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fpu_sequencer_if;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [4:0]  issue_rd;
  logic        issue_rd_fp;
  logic        kill;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rs3_idx;
  logic        rs1_en;
  logic        rs2_en;
  logic        rs3_en;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_rd_fp;
  logic        busy;
  logic        stall;
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_ops;

  // Core side drives issue and decode indices.
  modport master (
    output issue_valid, issue_op, issue_rd, issue_rd_fp, kill,
    output rs1_idx, rs2_idx, rs3_idx, rs1_en, rs2_en, rs3_en,
    input  fpu_start, fpu_op, wb_valid, wb_rd, wb_rd_fp, busy, stall,
    input  perf_busy_cycles, perf_ops
  );

  modport slave (
    input  issue_valid, issue_op, issue_rd, issue_rd_fp, kill,
    input  rs1_idx, rs2_idx, rs3_idx, rs1_en, rs2_en, rs3_en,
    output fpu_start, fpu_op, wb_valid, wb_rd, wb_rd_fp, busy, stall,
    output perf_busy_cycles, perf_ops
  );
endinterface

`default_nettype wire

// File: rtl/fpu_sequencer.sv
// ============================================================================
// fpu_sequencer : one-op-at-a-time FPU launcher with skid entry and hazard stall;
//                 define FPU_SEQ_PERF_EN to build the busy-cycle / op counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_sequencer #(
  parameter int ADD_LAT    = 3,
  parameter int MADD_LAT   = 5,
  parameter int CVT_LAT    = 2,
  parameter int SIMPLE_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  fpu_sequencer_if.slave bus
);

  // fpusel codes; SGNJ/ASEL/BSEL and unknown codes all take SIMPLE_LAT.
  localparam logic [2:0] FPU_ADD  = 3'd0;
  localparam logic [2:0] FPU_MADD = 3'd1;
  localparam logic [2:0] FPU_CVT  = 3'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_fp_q, rd_fp_d;
  logic             skid_q, skid_d;
  logic [2:0]       skid_op_q, skid_op_d;
  logic [4:0]       skid_rd_q, skid_rd_d;
  logic             skid_fp_q, skid_fp_d;

  logic       free, issue_ok, acceptable, drain, accept;
  logic       hz_cur, hz_skid, busy;
  logic [2:0] launch_op;

  function automatic logic [CNT_W-1:0] class_lat(input logic [2:0] op);
    case (op)
      FPU_ADD:  class_lat = CNT_W'(ADD_LAT);
      FPU_MADD: class_lat = CNT_W'(MADD_LAT);
      FPU_CVT:  class_lat = CNT_W'(CVT_LAT);
      default:  class_lat = CNT_W'(SIMPLE_LAT);
    endcase
  endfunction

  assign free       = (state_q == IDLE) || (state_q == WB);
  assign issue_ok   = bus.issue_valid && !bus.kill;
  assign acceptable = free && !skid_q;
  assign drain      = free && skid_q;
  assign accept     = acceptable && issue_ok;
  assign launch_op  = drain ? skid_op_q : bus.issue_op;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_fp_d   = rd_fp_q;
    skid_d    = skid_q;
    skid_op_d = skid_op_q;
    skid_rd_d = skid_rd_q;
    skid_fp_d = skid_fp_q;

    case (state_q)
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A launch out of WB goes straight back to RUN, so ops chain with no bubble.
    if (drain || accept) begin
      state_d = RUN;
      start_d = 1'b1;
      cnt_d   = class_lat(launch_op);
      op_d    = launch_op;
      rd_d    = drain ? skid_rd_q : bus.issue_rd;
      rd_fp_d = drain ? skid_fp_q : bus.issue_rd_fp;
    end

    // An issue arriving while the skid is already full is dropped.
    if (drain) begin
      skid_d = 1'b0;
    end else if (issue_ok && !acceptable && !skid_q) begin
      skid_d    = 1'b1;
      skid_op_d = bus.issue_op;
      skid_rd_d = bus.issue_rd;
      skid_fp_d = bus.issue_rd_fp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_fp_q   <= 1'b0;
      skid_q    <= 1'b0;
      skid_op_q <= '0;
      skid_rd_q <= '0;
      skid_fp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_fp_q   <= rd_fp_d;
      skid_q    <= skid_d;
      skid_op_q <= skid_op_d;
      skid_rd_q <= skid_rd_d;
      skid_fp_q <= skid_fp_d;
    end
  end

  // FP register 0 is a real register, so no index is exempt from the compare.
  assign hz_cur  = (state_q != IDLE) && rd_fp_q &&
                   ((bus.rs1_en && bus.rs1_idx == rd_q) ||
                    (bus.rs2_en && bus.rs2_idx == rd_q) ||
                    (bus.rs3_en && bus.rs3_idx == rd_q));
  assign hz_skid = skid_q && skid_fp_q &&
                   ((bus.rs1_en && bus.rs1_idx == skid_rd_q) ||
                    (bus.rs2_en && bus.rs2_idx == skid_rd_q) ||
                    (bus.rs3_en && bus.rs3_idx == skid_rd_q));

  assign busy          = (state_q != IDLE) || skid_q;
  assign bus.busy      = busy;
  assign bus.stall     = (state_q == RUN) || skid_q || hz_cur || hz_skid ||
                         (bus.issue_valid && !acceptable);
  assign bus.fpu_start = start_q;
  assign bus.fpu_op    = op_q;
  assign bus.wb_valid  = (state_q == WB);
  assign bus.wb_rd     = rd_q;
  assign bus.wb_rd_fp  = rd_fp_q;

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_ops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_ops_q  <= '0;
    end else begin
      if (busy)            perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == WB)   perf_ops_q  <= perf_ops_q + 32'd1;
    end
  end

  assign bus.perf_busy_cycles = perf_busy_q;
  assign bus.perf_ops         = perf_ops_q;
`else
  assign bus.perf_busy_cycles = '0;
  assign bus.perf_ops         = '0;
`endif

endmodule

`default_nettype wire
